// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the arbiter and the memory macro.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ack;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              pipe_stall;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, pipe_stall
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, pipe_stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for IF (fetch) and MEM (load/store) with fixed access latency.
// Optional fetch anti-starvation is enabled by defining ARB_ANTISTARVE_EN.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate (data before fetch)
// BUSY_I | fetch access on the memory port, cnt counts down to ack
// BUSY_D | data access on the memory port, cnt counts down to ack
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic                CLK,
   input logic                RESET,
   mem_port_arbiter_if.slave  bus
);

   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

   if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_param
      $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              mem_en_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;

   logic grant_d;
   logic last_cycle;
   logic if_ack_c;
   logic dm_ack_c;

`ifdef ARB_ANTISTARVE_EN
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [SW-1:0] starve_cnt;
   logic          force_fetch;

   assign force_fetch = bus.if_req && bus.dm_req && (starve_cnt == STARVE_LIM);
   assign grant_d     = bus.dm_req && !force_fetch;

   // Counts data grants that bypassed a waiting fetch; any other grant resets it.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         starve_cnt <= '0;
      end else if (state == IDLE) begin
         if (grant_d && bus.if_req) begin
            if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
         end else if (grant_d || bus.if_req) begin
            starve_cnt <= '0;
         end
      end
   end
`else
   assign grant_d = bus.dm_req;
`endif

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state       <= IDLE;
         cnt         <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state       <= BUSY_D;
                  cnt         <= LAT_M1;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= bus.dm_we;
                  mem_addr_q  <= bus.dm_addr;
                  mem_wdata_q <= bus.dm_wdata;
               end else if (bus.if_req) begin
                  state       <= BUSY_I;
                  cnt         <= LAT_M1;
                  mem_en_q    <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= bus.if_addr;
                  mem_wdata_q <= '0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (cnt == '0) begin
                  state       <= IDLE;
                  mem_en_q    <= 1'b0;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               cnt         <= '0;
               mem_en_q    <= 1'b0;
               mem_we_q    <= 1'b0;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
            end
         endcase
      end
   end

   // Acks fire in the final access cycle so the requester can re-arm at the next edge.
   assign last_cycle = (cnt == '0);
   assign if_ack_c   = (state == BUSY_I) && last_cycle;
   assign dm_ack_c   = (state == BUSY_D) && last_cycle;

   assign bus.if_ack    = if_ack_c;
   assign bus.dm_ack    = dm_ack_c;
   assign bus.if_rdata  = if_ack_c ? bus.mem_rdata : '0;
   assign bus.dm_rdata  = (dm_ack_c && !mem_we_q) ? bus.mem_rdata : '0;

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   assign bus.pipe_stall = (bus.if_req & ~if_ack_c) | (bus.dm_req & ~dm_ack_c);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=2): cycle tables plus
// hand sequences for reset abort and fetch starvation.
module tb_mem_port_arbiter;

   logic clk;
   logic rst_n;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(2)
   ) dut (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        dm_req;
      logic        dm_we;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic [31:0] mem_rdata;
      logic        e_en;
      logic        e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic        e_if_ack;
      logic [31:0] e_if_rdata;
      logic        e_dm_ack;
      logic [31:0] e_dm_rdata;
      logic        e_stall;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_errors = 0;

   function automatic logic [132:0] outs();
      return {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
              bus.if_ack, bus.if_rdata, bus.dm_ack, bus.dm_rdata, bus.pipe_stall};
   endfunction

   task automatic check(input string name, input logic [132:0] act, input logic [132:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd, input logic [31:0] mr,
                      input logic en, input logic we, input logic [31:0] ma, input logic [31:0] mw,
                      input logic ik, input logic [31:0] ird, input logic dk, input logic [31:0] drd,
                      input logic st);
      vec_t v;
      v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw; v.dm_addr = da;
      v.dm_wdata = dd; v.mem_rdata = mr; v.e_en = en; v.e_we = we; v.e_addr = ma;
      v.e_wdata = mw; v.e_if_ack = ik; v.e_if_rdata = ird; v.e_dm_ack = dk;
      v.e_dm_rdata = drd; v.e_stall = st;
      vecs.push_back(v);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic if_exp, dm_exp;

      rst_n = 1'b0;
      bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
      bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_rdata = 32'h1357_9BDF;

      // fetch read
      add(1, 32'h40, 0, 0, 0, 0, 32'h2010_0004,  0, 0, 0,      0,             0, 0,            0, 0,            1);
      add(1, 32'h40, 0, 0, 0, 0, 32'h2010_0004,  1, 0, 32'h40, 0,             0, 0,            0, 0,            1);
      add(1, 32'h40, 0, 0, 0, 0, 32'h2010_0004,  1, 0, 32'h40, 0,             1, 32'h2010_0004, 0, 0,           0);
      add(0, 0,      0, 0, 0, 0, 32'h2010_0004,  0, 0, 0,      0,             0, 0,            0, 0,            0);
      // store
      add(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678,  0, 0, 0,       0,             0, 0, 0, 0, 1);
      add(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678,  1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
      add(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678,  1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0,       0,             32'h1234_5678,  0, 0, 0,       0,             0, 0, 0, 0, 0);
      // load
      add(0, 0, 1, 0, 32'h200, 0, 32'hCAFE_F00D,  0, 0, 0,       0, 0, 0, 0, 0,             1);
      add(0, 0, 1, 0, 32'h200, 0, 32'hCAFE_F00D,  1, 0, 32'h200, 0, 0, 0, 0, 0,             1);
      add(0, 0, 1, 0, 32'h200, 0, 32'hCAFE_F00D,  1, 0, 32'h200, 0, 0, 0, 1, 32'hCAFE_F00D, 0);
      add(0, 0, 0, 0, 0,       0, 32'hCAFE_F00D,  0, 0, 0,       0, 0, 0, 0, 0,             0);
      // contention: data first, then fetch after one IDLE cycle
      add(1, 32'h80, 1, 0, 32'h300, 0, 32'hA5A5_A5A5,  0, 0, 0,       0, 0, 0,             0, 0,             1);
      add(1, 32'h80, 1, 0, 32'h300, 0, 32'hA5A5_A5A5,  1, 0, 32'h300, 0, 0, 0,             0, 0,             1);
      add(1, 32'h80, 1, 0, 32'h300, 0, 32'hA5A5_A5A5,  1, 0, 32'h300, 0, 0, 0,             1, 32'hA5A5_A5A5, 1);
      add(1, 32'h80, 0, 0, 0,       0, 32'hA5A5_A5A5,  0, 0, 0,       0, 0, 0,             0, 0,             1);
      add(1, 32'h80, 0, 0, 0,       0, 32'hA5A5_A5A5,  1, 0, 32'h80,  0, 0, 0,             0, 0,             1);
      add(1, 32'h80, 0, 0, 0,       0, 32'h5A5A_5A5A,  1, 0, 32'h80,  0, 1, 32'h5A5A_5A5A, 0, 0,             0);
      add(0, 0,      0, 0, 0,       0, 32'h5A5A_5A5A,  0, 0, 0,       0, 0, 0,             0, 0,             0);

      #3;
      check("reset_state", outs(), '0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      next_cycle();

      foreach (vecs[i]) begin
         bus.if_req    = vecs[i].if_req;
         bus.if_addr   = vecs[i].if_addr;
         bus.dm_req    = vecs[i].dm_req;
         bus.dm_we     = vecs[i].dm_we;
         bus.dm_addr   = vecs[i].dm_addr;
         bus.dm_wdata  = vecs[i].dm_wdata;
         bus.mem_rdata = vecs[i].mem_rdata;
         @(negedge clk);
         check($sformatf("vec%0d", i), outs(),
               {vecs[i].e_en, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wdata,
                vecs[i].e_if_ack, vecs[i].e_if_rdata, vecs[i].e_dm_ack,
                vecs[i].e_dm_rdata, vecs[i].e_stall});
         next_cycle();
      end

      // reset asserted in the second BUSY_D cycle of a store
      bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h104; bus.dm_wdata = 32'h11;
      bus.mem_rdata = 32'h77;
      next_cycle();
      check("rst_busy1_en", {132'd0, bus.mem_en}, {132'd0, 1'b1});
      next_cycle();
      #2;
      rst_n = 1'b0;
      bus.dm_req = 0; bus.dm_we = 0;
      #1;
      check("rst_abort", outs(), '0);
      @(negedge clk) rst_n = 1'b1;
      next_cycle();
      for (int c = 0; c < 4; c++) begin
         bus.if_req  = (c < 3);
         bus.if_addr = 32'h44;
         @(negedge clk);
         check($sformatf("rst_fetch_c%0d", c),
               {130'd0, bus.mem_en, bus.if_ack, bus.mem_we},
               {130'd0, (c == 1 || c == 2), (c == 2), 1'b0});
         next_cycle();
      end

      // back-to-back loads with a fetch waiting
      bus.if_addr = 32'h88; bus.dm_addr = 32'h400; bus.dm_we = 0; bus.mem_rdata = 32'h99;
      for (int c = 0; c < 15; c++) begin
`ifdef ARB_ANTISTARVE_EN
         bus.if_req = (c <= 8);
         bus.dm_req = 1'b1;
         if_exp = (c == 8);
         dm_exp = (c == 2 || c == 5 || c == 11 || c == 14);
`else
         bus.if_req = 1'b1;
         bus.dm_req = (c < 12);
         if_exp = (c == 14);
         dm_exp = (c == 2 || c == 5 || c == 8 || c == 11);
`endif
         @(negedge clk);
         check($sformatf("starve_c%0d", c), {131'd0, bus.if_ack, bus.dm_ack},
               {131'd0, if_exp, dm_exp});
         next_cycle();
      end
      bus.if_req = 0; bus.dm_req = 0;
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single-ported unified memory shared by the pipeline's IF stage (instruction fetch) and MEM stage (load/store). It grants one requester at a time and holds the memory port for a fixed access latency. It returns read data and a one-cycle ack to the granted requester, and produces a stall to the hazard logic (PCWrite/IFIDWrite gating) while any request is outstanding. It sits between the pipeline's fetch and data-memory interfaces and the memory macro.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory access cycles per transaction (>=1)
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits (anti-starvation only)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_ack  out  1  fetch done, 1-cycle pulse
- if_rdata  out  DATA_W  fetch data, valid with if_ack, else 0
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_ack  out  1  data done, 1-cycle pulse
- dm_rdata  out  DATA_W  load data, valid with dm_ack, else 0
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid on last access cycle
- pipe_stall  out  1  (if_req & ~if_ack) | (dm_req & ~dm_ack)

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - dm_req → BUSY_D.
  - else if_req → BUSY_I.
  - else stay in IDLE.
  - Data has priority over fetch.
- On grant, the edge latches the granted addr/we/wdata into mem_addr/mem_we/mem_wdata, sets mem_en=1 and sets cnt=MEM_LAT-1. mem_we is forced to 0 for BUSY_I.
- BUSY_x: cnt decrements each cycle.
  - When cnt==0, the corresponding ack is asserted combinationally for that cycle, with rdata = mem_rdata (0 for stores).
  - Next state is IDLE, and mem_en, mem_we, mem_addr and mem_wdata clear to 0.
- There is always one IDLE cycle between transactions. Requesters sample ack and update req/addr for the next access.
- A requester that drops req before ack is illegal. The transaction still completes, and its ack is ignored.
- rdata outputs are 0 whenever the matching ack is 0.

## Timing
- Reset values: every output is 0 and the FSM is in IDLE.
  - RESET low mid-transaction aborts immediately. The memory write is not completed beyond the cycles already driven.
  - After RESET is released, arbitration resumes on the first rising edge.
- Latency: req seen in IDLE at cycle 0 → mem_en high in cycles 1..MEM_LAT → ack in cycle MEM_LAT.
- Throughput: one access per MEM_LAT+1 cycles.
- Simultaneous if_req and dm_req in IDLE:
  - The data request is served first, ack in cycle MEM_LAT.
  - The fetch is granted at the IDLE edge after that, ack in cycle 2·MEM_LAT+1.
- pipe_stall is combinational and goes low in the ack cycle of the last outstanding request.

## Configuration
- ARB_ANTISTARVE_EN defined:
  - A starve counter increments on each data grant made while if_req is high. It clears on a fetch grant, or on a data grant made while if_req is low.
  - When the counter equals STARVE_MAX and both requests are present in IDLE, the fetch is granted.
- Macro undefined: strict data priority. The fetch waits indefinitely while dm_req stays high in IDLE.

## Test plan
All scenarios use MEM_LAT=2 and STARVE_MAX=2.
- Reset: assert RESET=0 in the 2nd BUSY_D cycle → all outputs 0 at once. Release, then assert if_req → mem_en in cycles 1–2 and if_ack in cycle 2.
- Fetch read: if_addr=0x0000_0040 with mem_rdata=0x2010_0004 → mem_addr=0x40 and mem_we=0 for 2 cycles. In cycle 2, if_ack=1 and if_rdata=0x2010_0004.
- Store: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF → mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF in cycles 1–2. dm_ack in cycle 2, dm_rdata=0, if_ack=0.
- Contention: if_req and dm_req both raised in cycle 0 → dm_ack in cycle 2, then IDLE in cycle 3. mem_en in cycles 4–5, if_ack in cycle 5. pipe_stall is high in cycles 0–4.
- Anti-starvation: dm_req re-asserted for back-to-back loads while if_req is held.
  - With ARB_ANTISTARVE_EN: the 3rd grant goes to fetch (if_ack in cycle 8).
  - Without: if_ack stays 0 until dm_req is dropped.
